// File: rtl/drum_irq_pkg.sv
// Shared constants for the drum trigger interrupt controller: register map and EVENT layout.
package drum_irq_pkg;

    localparam logic [2:0] ADDR_DATA  = 3'd0;
    localparam logic [2:0] ADDR_PEND  = 3'd1;
    localparam logic [2:0] ADDR_MASK  = 3'd2;
    localparam logic [2:0] ADDR_HOLD  = 3'd3;
    localparam logic [2:0] ADDR_EVENT = 3'd4;

    localparam int unsigned EVT_VALID_BIT = 31;
    localparam int unsigned CH_IDX_W      = 3;
    localparam int unsigned DATA_W        = 32;

endpackage

// File: rtl/drum_trig_chan.sv
// One trigger channel: 2-flop synchronizer, rising-edge detector and retrigger holdoff counter.
module drum_trig_chan #(
    parameter int unsigned HOLDOFF_W = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 trig,
    input  logic [HOLDOFF_W-1:0] holdoff,
    output logic                 sync,
    output logic                 fire_c
);

    logic                 meta;
    logic                 prev;
    logic [1:0]           warm;
    logic [HOLDOFF_W-1:0] cnt;
    logic                 rise;

    assign rise   = warm[1] & sync & ~prev;
    assign fire_c = rise & (cnt == '0);

    // prev is held high until the synchronizer has flushed its reset zeros,
    // so a line already high at reset release never looks like a fresh edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= 1'b0;
            sync <= 1'b0;
            prev <= 1'b1;
            warm <= 2'b00;
            cnt  <= '0;
        end else begin
            meta <= trig;
            sync <= meta;
            warm <= {warm[0], 1'b1};
            prev <= warm[1] ? sync : 1'b1;
            if (fire_c) begin
                cnt <= holdoff;
            end else if (cnt != '0) begin
                cnt <= cnt - HOLDOFF_W'(1);
            end
        end
    end

endmodule

// File: rtl/drum_trigger_irq_ctrl.sv
// Avalon-slave interrupt controller for drum pad triggers: per-channel pending latches,
// interrupt mask, retrigger holdoff and a round-robin EVENT register with acknowledge.
module drum_trigger_irq_ctrl
    import drum_irq_pkg::*;
#(
    parameter int unsigned NUM_CH    = 8,
    parameter int unsigned HOLDOFF_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [2:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    input  logic [NUM_CH-1:0] in_port,
    output logic              irq,
    output logic [31:0]       readdata
);

    logic [NUM_CH-1:0]    sync;
    logic [NUM_CH-1:0]    fire;
    logic [NUM_CH-1:0]    pending;
    logic [NUM_CH-1:0]    pend_nxt;
    logic [NUM_CH-1:0]    irq_mask;
    logic [HOLDOFF_W-1:0] holdoff;
    logic [CH_IDX_W-1:0]  rr_ptr;
    logic [CH_IDX_W-1:0]  grant;
    logic [CH_IDX_W-1:0]  rr_nxt;
    logic                 grant_valid;
    logic                 wr_en;
    logic                 ack_en;
    logic [DATA_W-1:0]    rd_nxt;
    logic                 unused_wdata;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
        drum_trig_chan #(
            .HOLDOFF_W (HOLDOFF_W)
        ) u_chan (
            .clk     (clk),
            .reset_n (reset_n),
            .trig    (in_port[i]),
            .holdoff (holdoff),
            .sync    (sync[i]),
            .fire_c  (fire[i])
        );
    end

    assign wr_en        = chipselect & ~write_n;
    assign ack_en       = wr_en && (address == ADDR_EVENT) && grant_valid;
    assign irq          = |(pending & irq_mask);
    assign unused_wdata = ^writedata;

    // Round-robin search from rr_ptr upward; scanning downward lets the lowest offset win.
    always_comb begin
        logic [7:0]          req;
        logic [CH_IDX_W:0]   idx;
        req         = 8'(pending & irq_mask);
        idx         = '0;
        grant_valid = 1'b0;
        grant       = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            idx = (CH_IDX_W+1)'(rr_ptr) + (CH_IDX_W+1)'(i);
            if (idx >= (CH_IDX_W+1)'(NUM_CH)) begin
                idx = idx - (CH_IDX_W+1)'(NUM_CH);
            end
            if (req[idx[CH_IDX_W-1:0]]) begin
                grant_valid = 1'b1;
                grant       = idx[CH_IDX_W-1:0];
            end
        end
        rr_nxt = (grant == CH_IDX_W'(NUM_CH - 1)) ? '0 : grant + CH_IDX_W'(1);
    end

    // Clears first, then new edges, so a set always wins over W1C or acknowledge.
    always_comb begin
        logic [7:0] ack_hot;
        ack_hot  = 8'd1 << grant;
        pend_nxt = pending;
        if (wr_en && (address == ADDR_PEND)) begin
            pend_nxt = pend_nxt & ~writedata[NUM_CH-1:0];
        end
        if (ack_en) begin
            pend_nxt = pend_nxt & ~ack_hot[NUM_CH-1:0];
        end
        pend_nxt = pend_nxt | fire;
    end

    always_comb begin
        rd_nxt = '0;
        case (address)
            ADDR_DATA:  rd_nxt = DATA_W'(sync);
            ADDR_PEND:  rd_nxt = DATA_W'(pending);
            ADDR_MASK:  rd_nxt = DATA_W'(irq_mask);
            ADDR_HOLD:  rd_nxt = DATA_W'(holdoff);
            ADDR_EVENT: begin
                rd_nxt                = DATA_W'(grant);
                rd_nxt[EVT_VALID_BIT] = grant_valid;
            end
            default:    rd_nxt = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending  <= '0;
            irq_mask <= '0;
            holdoff  <= '0;
            rr_ptr   <= '0;
            readdata <= '0;
        end else begin
            pending  <= pend_nxt;
            readdata <= rd_nxt;
            if (wr_en && (address == ADDR_MASK)) begin
                irq_mask <= writedata[NUM_CH-1:0];
            end
            if (wr_en && (address == ADDR_HOLD)) begin
                holdoff <= writedata[HOLDOFF_W-1:0];
            end
            if (ack_en) begin
                rr_ptr <= rr_nxt;
            end
        end
    end

endmodule

// File: tb/tb_drum_trigger_irq_ctrl.sv
// Self-checking bench for drum_trigger_irq_ctrl: register table, directed corner cases,
// and randomized traffic compared every cycle against a cycle-level reference model.
module tb_drum_trigger_irq_ctrl;

    localparam int NUM_CH    = 8;
    localparam int HOLDOFF_W = 16;

    logic              clk;
    logic              reset_n;
    logic [2:0]        address;
    logic              chipselect;
    logic              write_n;
    logic [31:0]       writedata;
    logic [NUM_CH-1:0] in_port;
    logic              irq;
    logic [31:0]       readdata;

    int vectors;
    int miscompares;
    bit chk_en;

    drum_trigger_irq_ctrl #(
        .NUM_CH    (NUM_CH),
        .HOLDOFF_W (HOLDOFF_W)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .in_port    (in_port),
        .irq        (irq),
        .readdata   (readdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Input history gives the synchronized view; a lockout deadline per channel stands in
    // for the holdoff counter (an edge is accepted when it arrives after the deadline).
    int                n;
    logic [7:0]        h1, h2, h3;
    logic [NUM_CH-1:0] m_pend, m_mask, m_nxt;
    logic [15:0]       m_hold;
    int                m_rr;
    int                lock_until [NUM_CH];
    logic [31:0]       m_rd;
    logic [7:0]        m_sync, m_fire;
    int                m_g;

    function automatic int grant_of();
        for (int k = 0; k < NUM_CH; k++) begin
            int c;
            c = (m_rr + k) % NUM_CH;
            if (m_pend[c] && m_mask[c]) return c;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            n = 0; m_pend = '0; m_mask = '0; m_hold = '0; m_rr = 0; m_rd = '0;
            for (int c = 0; c < NUM_CH; c++) lock_until[c] = -1;
        end else begin
            n++;
            m_sync = (n >= 3) ? h2 : 8'h00;
            m_g    = grant_of();
            case (address)
                3'd0:    m_rd = 32'(m_sync);
                3'd1:    m_rd = 32'(m_pend);
                3'd2:    m_rd = 32'(m_mask);
                3'd3:    m_rd = 32'(m_hold);
                3'd4:    m_rd = (m_g < 0) ? 32'h0 : (32'h8000_0000 | 32'(m_g));
                default: m_rd = 32'h0;
            endcase
            m_fire = '0;
            for (int c = 0; c < NUM_CH; c++) begin
                if (n >= 4 && h2[c] && !h3[c] && n > lock_until[c]) begin
                    m_fire[c]     = 1'b1;
                    lock_until[c] = n + int'(m_hold);
                end
            end
            m_nxt = m_pend;
            if (chipselect && !write_n) begin
                case (address)
                    3'd1: m_nxt = m_nxt & ~writedata[NUM_CH-1:0];
                    3'd2: m_mask = writedata[NUM_CH-1:0];
                    3'd3: m_hold = writedata[15:0];
                    3'd4: if (m_g >= 0) begin
                        m_nxt[m_g] = 1'b0;
                        m_rr = (m_g + 1) % NUM_CH;
                    end
                    default: ;
                endcase
            end
            m_pend = m_nxt | m_fire[NUM_CH-1:0];
            h3 = h2; h2 = h1; h1 = 8'(in_port);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_readdata", readdata, m_rd);
            check("model_irq", 32'(irq), 32'(|(m_pend & m_mask)));
        end
    end

    // ---------------- bus helpers ----------------
    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        address = a;
        @(negedge clk);
        d = readdata;
    endtask

    task automatic pulse(input logic [7:0] m);
        @(negedge clk);
        in_port = m;
        repeat (2) @(negedge clk);
        in_port = '0;
        repeat (4) @(negedge clk);
    endtask

    typedef struct {
        bit          do_wr;
        logic [2:0]  waddr;
        logic [31:0] wdata;
        logic [2:0]  raddr;
        logic [31:0] exp;
    } reg_vec_t;

    reg_vec_t    tbl [10];
    logic [31:0] rd;

    initial begin
        vectors = 0; miscompares = 0; chk_en = 1'b0;
        tbl[0] = '{1'b1, 3'd2, 32'h0000_00A5, 3'd2, 32'h0000_00A5};
        tbl[1] = '{1'b1, 3'd2, 32'hFFFF_FF3C, 3'd2, 32'h0000_003C};
        tbl[2] = '{1'b1, 3'd3, 32'hDEAD_BEEF, 3'd3, 32'h0000_BEEF};
        tbl[3] = '{1'b1, 3'd3, 32'h0000_0000, 3'd3, 32'h0000_0000};
        tbl[4] = '{1'b1, 3'd5, 32'hFFFF_FFFF, 3'd5, 32'h0000_0000};
        tbl[5] = '{1'b1, 3'd0, 32'h0000_00FF, 3'd0, 32'h0000_0000};
        tbl[6] = '{1'b1, 3'd1, 32'h0000_00FF, 3'd1, 32'h0000_0000};
        tbl[7] = '{1'b1, 3'd4, 32'h0000_0000, 3'd4, 32'h0000_0000};
        tbl[8] = '{1'b0, 3'd0, 32'h0000_0000, 3'd7, 32'h0000_0000};
        tbl[9] = '{1'b1, 3'd2, 32'h0000_0000, 3'd2, 32'h0000_0000};

        reset_n = 1'b0; address = '0; chipselect = 1'b0; write_n = 1'b1;
        writedata = '0; in_port = '0;
        repeat (3) @(negedge clk);
        check("reset_readdata", readdata, 32'h0);
        check("reset_irq", 32'(irq), 32'h0);
        chk_en  = 1'b1;
        reset_n = 1'b1;
        repeat (4) @(negedge clk);

        // register map table
        for (int i = 0; i < 10; i++) begin
            if (tbl[i].do_wr) bus_write(tbl[i].waddr, tbl[i].wdata);
            bus_read(tbl[i].raddr, rd);
            check($sformatf("reg_tbl[%0d]", i), rd, tbl[i].exp);
        end

        // round-robin order 1,3,6 from rr_ptr=0
        bus_write(3'd2, 32'hFF);
        pulse(8'h4A);
        bus_read(3'd1, rd);
        check("rr_pending", rd, 32'h4A);
        foreach (tbl[i]) if (i < 3) begin
            bus_read(3'd4, rd);
            check($sformatf("rr_event[%0d]", i), rd, 32'h8000_0000 | ((i == 0) ? 32'd1 : (i == 1) ? 32'd3 : 32'd6));
            bus_write(3'd4, 32'h0);
        end
        bus_read(3'd4, rd);
        check("rr_event_empty", rd, 32'h0);
        check("rr_irq_low", 32'(irq), 32'h0);

        // wrap from rr_ptr=7
        pulse(8'h82);
        bus_read(3'd4, rd);
        check("wrap_first", rd, 32'h8000_0007);
        bus_write(3'd4, 32'h0);
        bus_read(3'd4, rd);
        check("wrap_second", rd, 32'h8000_0001);
        bus_write(3'd4, 32'h0);
        bus_read(3'd4, rd);
        check("wrap_empty", rd, 32'h0);

        // single channel, no holdoff
        bus_write(3'd2, 32'h01);
        pulse(8'h01);
        check("ch0_irq", 32'(irq), 32'h1);
        bus_read(3'd1, rd);
        check("ch0_pending", rd, 32'h01);
        bus_read(3'd4, rd);
        check("ch0_event", rd, 32'h8000_0000);
        bus_write(3'd4, 32'h0);
        bus_read(3'd1, rd);
        check("ch0_acked", rd, 32'h0);

        // holdoff=10: edge 5 cycles later dropped, edge 12 cycles later accepted
        bus_write(3'd3, 32'd10);
        bus_write(3'd2, 32'h04);
        repeat (4) @(negedge clk);
        for (int j = 0; j <= 16; j++) begin
            @(negedge clk);
            case (j)
                0, 5, 12: in_port[2] = 1'b1;
                2, 7, 14: in_port[2] = 1'b0;
                3: begin
                    check("holdoff_first", 32'(irq), 32'h1);
                    address = 3'd1; writedata = 32'h04; chipselect = 1'b1; write_n = 1'b0;
                end
                4: begin chipselect = 1'b0; write_n = 1'b1; end
                9:  check("holdoff_dropped", 32'(irq), 32'h0);
                16: check("holdoff_rearmed", 32'(irq), 32'h1);
                default: ;
            endcase
        end
        bus_write(3'd1, 32'h04);
        bus_write(3'd3, 32'd0);
        repeat (4) @(negedge clk);

        // W1C colliding with a new edge on ch2: set wins
        pulse(8'h04);
        for (int j = 0; j <= 3; j++) begin
            @(negedge clk);
            case (j)
                0: in_port[2] = 1'b1;
                2: begin address = 3'd1; writedata = 32'h04; chipselect = 1'b1; write_n = 1'b0; end
                3: begin chipselect = 1'b0; write_n = 1'b1; in_port[2] = 1'b0; end
                default: ;
            endcase
        end
        bus_read(3'd1, rd);
        check("w1c_vs_set", rd, 32'h04);
        bus_write(3'd1, 32'h04);
        bus_read(3'd1, rd);
        check("w1c_clears", rd, 32'h0);

        // async reset mid-holdoff with pending=0x0F
        bus_write(3'd3, 32'd200);
        bus_write(3'd2, 32'h0F);
        pulse(8'h0F);
        bus_read(3'd1, rd);
        check("pre_reset_pending", rd, 32'h0F);
        @(negedge clk);
        #2 reset_n = 1'b0;
        in_port = 8'h01;
        #1;
        check("async_reset_irq", 32'(irq), 32'h0);
        check("async_reset_readdata", readdata, 32'h0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (8) @(negedge clk);
        for (int a = 1; a <= 4; a++) begin
            bus_read(3'(a), rd);
            check($sformatf("post_reset_addr%0d", a), rd, 32'h0);
        end
        in_port = '0;
        repeat (3) @(negedge clk);
        pulse(8'h01);
        bus_read(3'd1, rd);
        check("post_reset_new_edge", rd, 32'h01);

        // randomized traffic checked by the model every cycle
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            address    = 3'($urandom_range(0, 7));
            chipselect = 1'($urandom_range(0, 1));
            write_n    = ($urandom_range(0, 2) != 0);
            writedata  = (address == 3'd3) ? 32'($urandom_range(0, 20)) : $urandom;
            for (int b = 0; b < NUM_CH; b++) begin
                if ($urandom_range(0, 3) == 0) in_port[b] = ~in_port[b];
            end
        end
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1; in_port = '0;
        repeat (4) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/drum_trigger_irq_ctrl.md
DRUM_TRIGGER_IRQ_CTRL -- requirements
Module: drum_trigger_irq_ctrl

Interface
REQ-001 SHALL have parameter NUM_CH, default 8, number of trigger channels; legal values 2..8.
REQ-002 SHALL have parameter HOLDOFF_W, default 16, width of the retrigger holdoff counter.
REQ-003 SHALL have port clk, input, 1, the single system clock; one clock, all state on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port address, input, 3, Avalon slave word address.
REQ-006 SHALL have port chipselect, input, 1, slave select.
REQ-007 SHALL have port write_n, input, 1, active-low write strobe.
REQ-008 SHALL have port writedata, input, 32, write data.
REQ-009 SHALL have port in_port, input, NUM_CH, asynchronous drum pad trigger lines, active-high.
REQ-010 SHALL have port irq, output, 1, level interrupt to the CPU.
REQ-011 SHALL have port readdata, output, 32, registered read data.

Function
REQ-012 SHALL pass in_port through a 2-flop synchronizer; all later logic uses the synchronized value only.
REQ-013 SHALL detect a rising edge per channel as sync=1 with the previous sync=0.
REQ-014 SHALL, on an edge when the channel holdoff counter is 0, set pending[ch] and load the counter with HOLDOFF.
REQ-015 SHALL decrement a nonzero holdoff counter by 1 per cycle; it saturates at 0; edges while it is nonzero are dropped.
REQ-016 SHALL treat HOLDOFF=0 as no lockout, so every edge sets pending.
REQ-017 SHALL decode the register map at word addresses: 0 = sync inputs (RO); 1 = pending (write-1-to-clear); 2 = irq_mask (RW); 3 = HOLDOFF (RW, low HOLDOFF_W bits); 4 = EVENT (RO, a write acknowledges).
REQ-018 SHALL update readdata one cycle after the address is presented; unused bits and unmapped addresses read 0; readdata is not gated by chipselect.
REQ-019 SHALL drive irq = OR over (pending AND irq_mask), combinationally from registers.
REQ-020 SHALL arbitrate round-robin: grant = first channel with pending AND mask, searching from rr_ptr upward and wrapping at NUM_CH.
REQ-021 SHALL make EVENT read {bit31 = grant_valid, bits[2:0] = grant channel}, 0 when no grant.
REQ-022 SHALL, on a write to address 4 with grant_valid=1, clear pending[grant] and set rr_ptr = (grant+1) mod NUM_CH; with grant_valid=0 the write has no effect.
REQ-023 SHALL let set win when a new edge and a W1C or acknowledge target the same bit in the same cycle.
REQ-024 SHALL keep a masked pending bit latched; unmasking it later asserts irq.

Reset
REQ-025 SHALL reset to: readdata=0, pending=0, irq_mask=0, HOLDOFF=0, rr_ptr=0, all holdoff counters=0, synchronizer flops=0, irq=0.
REQ-026 SHALL, when reset asserts mid-holdoff or mid-event, abort immediately and discard edges captured before reset; the first edge detectable after release needs in_port low then high.

Structure
REQ-027 SHALL place the register address constants (ADDR_DATA=0, ADDR_PEND=1, ADDR_MASK=2, ADDR_HOLD=3, ADDR_EVENT=4) and the EVENT valid-bit index in the shared package drum_irq_pkg.
REQ-028 SHALL implement the per-channel synchronizer, edge detector and holdoff counter as one sub-module, drum_trig_chan, instantiated NUM_CH times.
REQ-029 SHALL keep the round-robin arbiter and the register file in the top module.

Verification
REQ-030 SHALL cover: HOLDOFF=0, mask=0x01, pulse in_port[0] -> pending=0x01 within 4 cycles of the rising edge, irq=1, EVENT=0x80000000.
REQ-031 SHALL cover: HOLDOFF=10, two edges on ch2 spaced 5 cycles -> only the first sets pending; a third edge 12 cycles after the first sets it again.
REQ-032 SHALL cover: mask=0xFF, pending ch1, ch3 and ch6, rr_ptr=0 -> successive EVENT reads/acks yield 1, 3, 6, then EVENT=0 and irq=0.
REQ-033 SHALL cover: after acking ch6, pend ch1 and ch7 -> next grant=7 (wrap from rr_ptr=7), then 1.
REQ-034 SHALL cover: W1C 0x04 in the same cycle as a new synchronized edge on ch2 -> pending[2] stays 1.
REQ-035 SHALL cover: reset_n pulsed low mid-holdoff with pending=0x0F -> all registers 0 asynchronously, irq=0 before the next clk edge.
